// File: rtl/seg_scan_driver.sv
// Multiplexed 5-digit 7-segment scanner showing result/b/a/s/update-count, with frame-synchronous shadow transfer.
// Latency: SEG_SEL/SEG_DATA registered, 1 cycle behind scan state; load is always accepted (no backpressure), load_ack pulses after the transfer.
module seg_scan_driver #(
    parameter int DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic [1:0] s,
    input  logic [3:0] result,
    output logic       load_ack,
    output logic [4:0] SEG_SEL,
    output logic [7:0] SEG_DATA
);
    localparam int CW = $clog2(DIV);

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] s;
        logic [3:0] res;
    } digits_t;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic          r_pending;
    logic          r_valid;
    logic [3:0]    r_upd_cnt;
    digits_t       r_shadow;
    digits_t       r_disp;
    logic          r_load_ack;
    logic [4:0]    r_seg_sel;
    logic [7:0]    r_seg_data;

    logic          w_cnt_last;
    logic          w_boundary;
    logic          w_xfer;
    logic [3:0]    w_nib;
    logic [4:0]    w_sel_nxt;
    logic [7:0]    w_data_nxt;

    function automatic logic [6:0] f_hex(input logic [3:0] n);
        case (n)
            4'h0: f_hex = 7'h3F;
            4'h1: f_hex = 7'h06;
            4'h2: f_hex = 7'h5B;
            4'h3: f_hex = 7'h4F;
            4'h4: f_hex = 7'h66;
            4'h5: f_hex = 7'h6D;
            4'h6: f_hex = 7'h7D;
            4'h7: f_hex = 7'h07;
            4'h8: f_hex = 7'h7F;
            4'h9: f_hex = 7'h6F;
            4'hA: f_hex = 7'h77;
            4'hB: f_hex = 7'h7C;
            4'hC: f_hex = 7'h39;
            4'hD: f_hex = 7'h5E;
            4'hE: f_hex = 7'h79;
            default: f_hex = 7'h71;
        endcase
    endfunction

    assign w_cnt_last = (r_cnt == CW'(DIV - 1));
    assign w_boundary = w_cnt_last && (r_idx == 3'd4);
    // Transfer only at the frame edge so a frame never mixes old and new digits.
    assign w_xfer     = w_boundary && r_pending;

    always_comb begin
        w_nib = r_upd_cnt;
        case (r_idx)
            3'd0:    w_nib = r_disp.res;
            3'd1:    w_nib = {2'b00, r_disp.b};
            3'd2:    w_nib = {2'b00, r_disp.a};
            3'd3:    w_nib = {2'b00, r_disp.s};
            default: w_nib = r_upd_cnt;
        endcase
    end

    // Slot 0 of each digit is blanked to hide ghosting while the select lines switch.
    always_comb begin
        w_sel_nxt  = 5'b00000;
        w_data_nxt = 8'h00;
        if (r_cnt != '0) begin
            w_sel_nxt  = 5'b00001 << r_idx;
            w_data_nxt = r_valid ? {1'b0, f_hex(w_nib)} : 8'h40;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_idx      <= 3'd0;
            r_pending  <= 1'b0;
            r_valid    <= 1'b0;
            r_upd_cnt  <= 4'd0;
            r_shadow   <= '0;
            r_disp     <= '0;
            r_load_ack <= 1'b0;
            r_seg_sel  <= 5'b00000;
            r_seg_data <= 8'h00;
        end else begin
            r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
            if (w_cnt_last) begin
                r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
            end
            if (load) begin
                r_shadow <= {a, b, s, result};
            end
            r_pending  <= load | (r_pending & ~w_boundary);
            r_load_ack <= w_xfer;
            if (w_xfer) begin
                r_disp    <= r_shadow;
                r_valid   <= 1'b1;
                r_upd_cnt <= r_upd_cnt + 4'd1;
            end
            r_seg_sel  <= w_sel_nxt;
            r_seg_data <= w_data_nxt;
        end
    end

    assign load_ack = r_load_ack;
    assign SEG_SEL  = r_seg_sel;
    assign SEG_DATA = r_seg_data;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIV = 4 (20-cycle frames).
module tb_seg_scan_driver;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [1:0] a = 2'd0;
    logic [1:0] b = 2'd0;
    logic [1:0] s = 2'd0;
    logic [3:0] result = 4'd0;
    logic       load_ack;
    logic [4:0] SEG_SEL;
    logic [7:0] SEG_DATA;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] HEX [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    seg_scan_driver #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .a        (a),
        .b        (b),
        .s        (s),
        .result   (result),
        .load_ack (load_ack),
        .SEG_SEL  (SEG_SEL),
        .SEG_DATA (SEG_DATA)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [9:0] pk(input logic [1:0] pa, input logic [1:0] pb,
                                      input logic [1:0] ps, input logic [3:0] pr);
        return {pa, pb, ps, pr};
    endfunction

    // One full frame of outputs; e0..e4 are the segment bytes expected for idx0..idx4.
    // off1/off2 give the frame cycle (1..19) during which load is held high, 0 for none.
    task automatic run_frame(input string tag,
                             input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                             input logic [7:0] e3, input logic [7:0] e4, input logic ack_end,
                             input int off1, input logic [9:0] d1,
                             input int off2, input logic [9:0] d2);
        logic [7:0] e [5];
        logic [4:0] xs;
        logic [7:0] xd;
        int         q;
        e = '{e0, e1, e2, e3, e4};
        for (int i = 1; i <= 20; i++) begin
            tick();
            q  = i - 1;
            xs = (q % DIV == 0) ? 5'd0 : 5'(1 << (q / DIV));
            xd = (xs == 5'd0) ? 8'h00 : e[q / DIV];
            chk({tag, "/sel"}, {3'b000, SEG_SEL}, {3'b000, xs});
            chk({tag, "/data"}, SEG_DATA, xd);
            chk({tag, "/ack"}, {7'd0, load_ack}, {7'd0, (i == 20) ? ack_end : 1'b0});
            load = 1'b0;
            if (i == off1) begin
                load = 1'b1;
                {a, b, s, result} = d1;
            end
            if (i == off2) begin
                load = 1'b1;
                {a, b, s, result} = d2;
            end
        end
        load = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst/sel", {3'b000, SEG_SEL}, 8'h00);
        chk("rst/data", SEG_DATA, 8'h00);
        chk("rst/ack", {7'd0, load_ack}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;

        // Dashes, load at cycle 5, ack right after the cycle-19 boundary.
        run_frame("f0", 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 1'b1, 5, pk(2, 3, 3, 6), 0, '0);
        run_frame("f1", 8'h7D, 8'h4F, 8'h5B, 8'h4F, 8'h06, 1'b0, 0, '0, 0, '0);
        // Two loads in one frame: only the second is shown, one ack.
        run_frame("f2", 8'h7D, 8'h4F, 8'h5B, 8'h4F, 8'h06, 1'b1, 3, pk(0, 0, 0, 1), 10, pk(1, 2, 0, 9));
        run_frame("f3", 8'h6F, 8'h5B, 8'h06, 8'h3F, 8'h5B, 1'b0, 0, '0, 0, '0);
        // Load on the boundary cycle with nothing pending: transfer waits a frame.
        run_frame("f4", 8'h6F, 8'h5B, 8'h06, 8'h3F, 8'h5B, 1'b0, 19, pk(3, 1, 2, 4'hA), 0, '0);
        run_frame("f5", 8'h6F, 8'h5B, 8'h06, 8'h3F, 8'h5B, 1'b1, 0, '0, 0, '0);
        // Load on the boundary with data pending: old shadow transfers, new one follows.
        run_frame("f6", 8'h77, 8'h06, 8'h4F, 8'h5B, 8'h4F, 1'b1, 2, pk(0, 0, 0, 4'hC), 19, pk(0, 0, 0, 4'hE));
        run_frame("f7", 8'h39, 8'h3F, 8'h3F, 8'h3F, 8'h66, 1'b1, 0, '0, 0, '0);
        run_frame("f8", 8'h79, 8'h3F, 8'h3F, 8'h3F, 8'h6D, 1'b0, 0, '0, 0, '0);

        // Mid-frame reset with a load pending.
        for (int i = 1; i <= 8; i++) begin
            tick();
            load = (i == 3);
            if (i == 3) {a, b, s, result} = pk(1, 1, 1, 1);
        end
        chk("pre_rst/sel", {3'b000, SEG_SEL}, 8'h02);
        chk("pre_rst/data", SEG_DATA, 8'h3F);
        rst_n = 1'b0;
        #1;
        chk("mid_rst/sel", {3'b000, SEG_SEL}, 8'h00);
        chk("mid_rst/data", SEG_DATA, 8'h00);
        chk("mid_rst/ack", {7'd0, load_ack}, 8'h00);
        tick();
        tick();
        chk("hold_rst/sel", {3'b000, SEG_SEL}, 8'h00);
        chk("hold_rst/data", SEG_DATA, 8'h00);
        rst_n = 1'b1;
        cyc = 0;
        run_frame("r0", 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 1'b0, 0, '0, 0, '0);

        // Sixteen transfers: update-count digit walks 1..F then wraps to 0.
        run_frame("r1", 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 1'b1, 7, pk(0, 0, 0, 4'd0), 0, '0);
        for (int k = 1; k <= 15; k++) begin
            run_frame("wrap", HEX[k - 1], 8'h3F, 8'h3F, 8'h3F, HEX[k], 1'b1, 7, pk(0, 0, 0, 4'(k)), 0, '0);
        end
        run_frame("wrap_end", 8'h71, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 1'b0, 0, '0, 0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter DIV, default 1000: clock cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port load, input, 1: single-cycle strobe; capture a, b, s and result.
REQ-005 SHALL have port a, input, 2: operand A from the ALU stage.
REQ-006 SHALL have port b, input, 2: operand B.
REQ-007 SHALL have port s, input, 2: operation select.
REQ-008 SHALL have port result, input, 4: ALU result, 0..15.
REQ-009 SHALL have port load_ack, output, 1: one-cycle pulse when captured data reaches the display.
REQ-010 SHALL have port SEG_SEL, output, 5: digit enable, active-high; bit i enables digit i.
REQ-011 SHALL have port SEG_DATA, output, 8: segments; bit7 = dp, bits 6..0 = g..a, active-high.

Function
REQ-012 SHALL keep a slot counter cnt running 0..DIV-1, wrapping to 0, and a digit index idx running 0..4, wrapping to 0; idx advances only when cnt wraps.
REQ-013 SHALL make a frame 5*DIV cycles; the frame boundary is the cycle with cnt = DIV-1 and idx = 4.
REQ-014 SHALL register SEG_SEL and SEG_DATA; both reflect cnt, idx and the display register with exactly 1 cycle of latency.
REQ-015 SHALL blank for ghosting: when cnt = 0, SEG_SEL = 5'b00000 and SEG_DATA = 8'h00; for cnt = 1..DIV-1, SEG_SEL = one-hot(idx).
REQ-016 SHALL use this digit content: idx0 = result, idx1 = b, idx2 = a, idx3 = s, idx4 = frame-update count upd_cnt (4 bits); dp is always 0.
REQ-017 SHALL use this hex encoding: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
REQ-018 SHALL drive every enabled digit as dash 8'h40 until the first transfer after reset.
REQ-019 SHALL handle load as follows: when load = 1, a, b, s and result go into a shadow register and pending is set, regardless of scan state.
REQ-020 SHALL transfer at a frame boundary with pending = 1: shadow copies to the display register, pending clears, upd_cnt increments, and load_ack = 1 in the following cycle.
REQ-021 SHALL wrap upd_cnt 15 -> 0.
REQ-022 SHALL let a later load before transfer overwrite the shadow; only the last load is displayed; one transfer produces one ack and one upd_cnt increment.
REQ-023 SHALL handle load coinciding with a frame boundary as follows: the transfer uses the pre-edge shadow contents; the new data is captured and pending remains 1 for the next boundary. If pending was 0, no transfer happens this boundary.
REQ-024 SHALL never change displayed content mid-frame.

Reset
REQ-025 SHALL, while rst_n = 0 (asynchronous), force: cnt = 0, idx = 0, pending = 0, valid = 0, upd_cnt = 0, shadow and display registers = 0, load_ack = 0, SEG_SEL = 5'b00000, SEG_DATA = 8'h00.
REQ-026 SHALL restart scanning from idx 0, cnt 0 on the first edge after rst_n rises; reset mid-frame or mid-pending discards the pending data.

Verification
REQ-027 SHALL cover, with DIV = 4 and no load: SEG_SEL sequence per slot is 00000, then 00001 x3, then 00000, then 00010 x3, ... through 10000, then repeats; SEG_DATA = 40 whenever enabled.
REQ-028 SHALL cover load a=2, b=3, s=3, result=6 at cycle 5: load_ack one cycle after the cycle-19 boundary; the next frame shows 7D, 4F, 5B, 4F, 06.
REQ-029 SHALL cover two loads in one frame (result 1, then result 9): only 6F is shown at idx0; exactly one ack; upd_cnt = 1.
REQ-030 SHALL cover load asserted on the boundary cycle with pending = 0: no ack at that boundary; the ack and display update come at the next boundary.
REQ-031 SHALL cover 16 frames each with one load: upd_cnt digit goes 1..F, then 0 (3F).
REQ-032 SHALL cover rst_n pulsed low mid-frame with pending = 1: outputs are 00 immediately, dashes after release, and no ack.
